// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: controller state encoding.
// Encodings match the counter project's IDLE/RUN/DONE values.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// DIV prescaler: tick_o is high on the cycle the prescaler sits at DIV-1.
// Only instantiated for DIV > 1.
module countdown_timer_tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic hold_i,
  output logic tick_o
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == CW'(DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, regardless of block ordering.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (!hold_i) begin
      cnt_q <= tick_o ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaled decrement, terminal-count flag and
// optional auto-reload from the last loaded value.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DIV    = 1,
  parameter bit RELOAD = 1'b0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             pause_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] latch_q, latch_d;
  logic             tick;

  generate
    if (DIV > 1) begin : g_presc
      // Prescaler restarts on every load and is parked at zero outside RUN.
      countdown_timer_tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (start_i || (state_q != ST_RUN)),
        .hold_i  (pause_i),
        .tick_o  (tick)
      );
    end else begin : g_no_presc
      assign tick = 1'b1;
    end
  endgenerate

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    latch_d = latch_q;
    if (start_i) begin
      latch_d = load_val_i;
      count_d = load_val_i;
      state_d = (load_val_i != '0) ? ST_RUN : ST_DONE;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (!pause_i && tick) begin
            count_d = count_q - WIDTH'(1);
            if (count_q == WIDTH'(1)) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          count_d = '0;
          if (RELOAD && (latch_q != '0)) begin
            count_d = latch_q;
            state_d = ST_RUN;
          end else if (!RELOAD) begin
            state_d = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      latch_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      latch_q <= latch_d;
    end
  end

  assign count_o = count_q;
  assign busy_o  = (state_q == ST_RUN);
  assign done_o  = (state_q == ST_DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: three instances (DIV=1 one-shot,
// DIV=3 one-shot, DIV=1 auto-reload) checked against a scoreboard queue.
module tb_countdown_timer;

  logic clk = 1'b0;
  logic reset;

  logic       start0, start1, start2;
  logic [3:0] load0, load1, load2;
  logic       pause0, pause1, pause2;
  logic [3:0] cnt0, cnt1, cnt2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(4), .DIV(1), .RELOAD(1'b0)) u_d1 (
    .clk_i(clk), .reset_i(reset), .start_i(start0), .load_val_i(load0),
    .pause_i(pause0), .count_o(cnt0), .busy_o(busy0), .done_o(done0));

  countdown_timer #(.WIDTH(4), .DIV(3), .RELOAD(1'b0)) u_d3 (
    .clk_i(clk), .reset_i(reset), .start_i(start1), .load_val_i(load1),
    .pause_i(pause1), .count_o(cnt1), .busy_o(busy1), .done_o(done1));

  countdown_timer #(.WIDTH(4), .DIV(1), .RELOAD(1'b1)) u_rl (
    .clk_i(clk), .reset_i(reset), .start_i(start2), .load_val_i(load2),
    .pause_i(pause2), .count_o(cnt2), .busy_o(busy2), .done_o(done2));

  typedef struct {
    string      tag;
    int         dut;
    logic [3:0] cnt;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  function automatic logic [5:0] obs(int d);
    case (d)
      0:       return {cnt0, busy0, done0};
      1:       return {cnt1, busy1, done1};
      default: return {cnt2, busy2, done2};
    endcase
  endfunction

  task automatic expect_o(string tag, int dut, logic [3:0] c, logic b, logic d);
    exp_t e;
    e.tag = tag; e.dut = dut; e.cnt = c; e.busy = b; e.done = d;
    sb.push_back(e);
  endtask

  // Advance one clock, then compare every expectation queued for this edge.
  task automatic cyc();
    exp_t       e;
    logic [5:0] act;
    logic [5:0] want;
    @(posedge clk);
    #1;
    while (sb.size() != 0) begin
      e    = sb.pop_front();
      act  = obs(e.dut);
      want = {e.cnt, e.busy, e.done};
      n_cmp++;
      assert (act === want) else begin
        n_mis++;
        $error("FAIL %s dut%0d observed cnt=%0d busy=%b done=%b expected cnt=%0d busy=%b done=%b",
               e.tag, e.dut, act[5:2], act[1], act[0], e.cnt, e.busy, e.done);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    load0  = '0;   load1  = '0;   load2  = '0;
    pause0 = 1'b0; pause1 = 1'b0; pause2 = 1'b0;

    // Reset for two cycles, then idle with no start.
    cyc();
    for (int d = 0; d < 3; d++) expect_o("reset_state", d, 4'd0, 1'b0, 1'b0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int d = 0; d < 3; d++) expect_o("idle_hold", d, 4'd0, 1'b0, 1'b0);
      cyc();
    end

    // DIV=1 one-shot from 5.
    start0 = 1'b1; load0 = 4'd5;
    expect_o("d1_load", 0, 4'd5, 1'b1, 1'b0);
    cyc();
    start0 = 1'b0; load0 = 4'd0;
    for (int v = 4; v >= 1; v--) begin
      expect_o("d1_count", 0, 4'(v), 1'b1, 1'b0);
      cyc();
    end
    expect_o("d1_done", 0, 4'd0, 1'b0, 1'b1);
    cyc();
    expect_o("d1_after_done", 0, 4'd0, 1'b0, 1'b0);
    cyc();
    expect_o("d1_stay_idle", 0, 4'd0, 1'b0, 1'b0);
    cyc();

    // DIV=3 from 2 with a 4-cycle pause while the prescaler is mid-period.
    start1 = 1'b1; load1 = 4'd2;
    expect_o("d3_load", 1, 4'd2, 1'b1, 1'b0);
    cyc();
    start1 = 1'b0;
    expect_o("d3_e1", 1, 4'd2, 1'b1, 1'b0); cyc();
    expect_o("d3_e2", 1, 4'd2, 1'b1, 1'b0); cyc();
    expect_o("d3_e3", 1, 4'd1, 1'b1, 1'b0); cyc();
    expect_o("d3_e4", 1, 4'd1, 1'b1, 1'b0); cyc();
    pause1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_o("d3_paused", 1, 4'd1, 1'b1, 1'b0);
      cyc();
    end
    pause1 = 1'b0;
    expect_o("d3_e9", 1, 4'd1, 1'b1, 1'b0); cyc();
    expect_o("d3_done_e10", 1, 4'd0, 1'b0, 1'b1); cyc();
    expect_o("d3_idle", 1, 4'd0, 1'b0, 1'b0); cyc();

    // Start with zero goes straight to DONE without ever being busy.
    start0 = 1'b1; load0 = 4'd0;
    expect_o("zero_done", 0, 4'd0, 1'b0, 1'b1);
    cyc();
    start0 = 1'b0;
    expect_o("zero_idle", 0, 4'd0, 1'b0, 1'b0);
    cyc();

    // Restart mid-count on DIV=3: the prescaler must restart from zero.
    start1 = 1'b1; load1 = 4'd4;
    expect_o("rs_load4", 1, 4'd4, 1'b1, 1'b0); cyc();
    start1 = 1'b0;
    expect_o("rs_4a", 1, 4'd4, 1'b1, 1'b0); cyc();
    expect_o("rs_4b", 1, 4'd4, 1'b1, 1'b0); cyc();
    expect_o("rs_3a", 1, 4'd3, 1'b1, 1'b0); cyc();
    expect_o("rs_3b", 1, 4'd3, 1'b1, 1'b0); cyc();
    start1 = 1'b1; load1 = 4'd9;
    expect_o("rs_load9", 1, 4'd9, 1'b1, 1'b0); cyc();
    start1 = 1'b0;
    expect_o("rs_9a", 1, 4'd9, 1'b1, 1'b0); cyc();
    expect_o("rs_9b", 1, 4'd9, 1'b1, 1'b0); cyc();
    expect_o("rs_8", 1, 4'd8, 1'b1, 1'b0); cyc();

    // Auto-reload from 3: 3,2,1,0 repeating, done once per 4 cycles.
    start2 = 1'b1; load2 = 4'd3;
    expect_o("rl_load", 2, 4'd3, 1'b1, 1'b0); cyc();
    start2 = 1'b0;
    for (int p = 0; p < 3; p++) begin
      expect_o("rl_2", 2, 4'd2, 1'b1, 1'b0); cyc();
      expect_o("rl_1", 2, 4'd1, 1'b1, 1'b0); cyc();
      expect_o("rl_done", 2, 4'd0, 1'b0, 1'b1); cyc();
      expect_o("rl_reload", 2, 4'd3, 1'b1, 1'b0); cyc();
    end

    // Reset mid-count wins over a simultaneous start.
    start0 = 1'b1; load0 = 4'd6;
    expect_o("rst_load6", 0, 4'd6, 1'b1, 1'b0); cyc();
    start0 = 1'b0;
    expect_o("rst_5", 0, 4'd5, 1'b1, 1'b0); cyc();
    expect_o("rst_4", 0, 4'd4, 1'b1, 1'b0); cyc();
    reset = 1'b1; start0 = 1'b1; load0 = 4'd7;
    for (int d = 0; d < 3; d++) expect_o("rst_mid_run", d, 4'd0, 1'b0, 1'b0);
    cyc();
    reset = 1'b0; start0 = 1'b0; load0 = 4'd0;
    for (int i = 0; i < 3; i++) begin
      for (int d = 0; d < 3; d++) expect_o("rst_after", d, 4'd0, 1'b0, 1'b0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter; the decrementing counterpart to the counter datapath's 4-bit incrementing adder.
- Accepts a start value, decrements once per prescaled tick, and signals terminal count.
- Optional auto-reload for periodic operation.
- Sits beside the up-counter in the counter project; drives timeout/terminal-count logic.

Parameters:
WIDTH, 4, width of load value and count.
DIV, 1, clock cycles per decrement; legal range >= 1.
RELOAD, 0, 1 = restart from latched load value after terminal count; 0 = one-shot.

Ports:
clk  input  1  system clock, all state updates on rising edge.
reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
start  input  1  load load_val and begin counting; sampled each edge.
load_val  input  WIDTH  start value, captured when start=1.
pause  input  1  freeze count and prescaler while high.
count  output  WIDTH  current count value (registered).
busy  output  1  high in RUN state.
done  output  1  high exactly while in DONE state (registered).

Behaviour:
- Reset: state IDLE, count=0, busy=0, done=0, prescaler=0, latched value=0. Reset overrides every input, including mid-count.
- States: IDLE, RUN, DONE. busy=(state==RUN); done=(state==DONE).
- IDLE:
  - start=1 with load_val!=0 -> RUN; count<=load_val; latch<=load_val; prescaler<=0.
  - start=1 with load_val==0 -> DONE; count<=0.
  - Otherwise hold.
- RUN:
  - start=1 -> restart exactly as from IDLE. start has priority over pause and over the decrement.
  - pause=1 -> hold count and prescaler; stay RUN.
  - Otherwise prescaler advances. When prescaler==DIV-1: prescaler<=0 and count<=count-1.
  - A decrement taking count 1->0 moves the state to DONE on the same edge.
- DONE: lasts one cycle unless rules below say otherwise; count=0.
  - start=1 -> restart as from IDLE.
  - Else RELOAD=1 with latch!=0 -> RUN; count<=latch; prescaler<=0.
  - Else RELOAD=1 with latch==0 -> stay DONE, so done is held high.
  - Else -> IDLE.
- Timing (DIV=1): start at edge E0 with N>0.
  - count=N after E0; decrements at E1..EN.
  - count=0 and done=1 after EN; done=0 after EN+1 (one-shot).
  - General case: N*DIV edges after E0 to reach DONE, plus paused cycles.
- Arithmetic: unsigned WIDTH bits. count never wraps below 0, since reaching 0 always leaves RUN.
- pause has no effect in IDLE or DONE.
- start while busy always restarts; no error flag.
- DIV=1: prescaler is degenerate and a decrement happens every unpaused RUN cycle.

Decomposition:
- Shared include file counter_defs.vh holds the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) for use across the counter project.
- One natural sub-module: tick_gen, the DIV prescaler.
  - Inputs: clk, reset, clear, hold.
  - Output: tick, asserted on the prescaler==DIV-1 cycle.
  - Instantiated only when DIV>1; otherwise tick is tied high.

Test Plan:
- Reset high 2 cycles, then low -> count=0, busy=0, done=0; idle with no start for 5 cycles -> outputs unchanged.
- DIV=1, load_val=5, start one cycle -> count 5,4,3,2,1,0 on successive cycles; done=1 for exactly one cycle with count=0; busy low afterwards.
- DIV=3, load_val=2, pause high for 4 cycles mid-count -> done asserts 6+4=10 edges after the start edge; count frozen during pause.
- start=1 with load_val=0 -> done=1 on the next cycle, busy never high; start with load_val=9 while count=3 -> count=9 next cycle, prescaler cleared.
- RELOAD=1, load_val=3, DIV=1 -> count sequence 3,2,1,0,3,2,1,0…; done pulses every 4 cycles.
- Reset asserted while count=4 in RUN -> next cycle count=0, busy=0, done=0; a start applied on the same edge as reset is ignored.
